// File: rtl/mul_pkg.sv
// Shared types and constants for the shift-and-add multiplier.
// Optional EARLY_ZERO_EN lives in shift_add_multiplier.sv.
package mul_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int WIDTH = 32;
  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0] LAST_ITER = 5'd31;
endpackage

// File: rtl/shift_add_multiplier_adder32.sv
// Adder32Bit: 32-bit ripple-carry adder with carry-in and carry-out.
// Shared datapath block reused by the multiplier.
module Adder32Bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);
  always_comb begin
    logic carry;
    carry = cin;
    sum   = '0;
    for (int i = 0; i < 32; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end
endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned 32x32->64 shift-and-add multiplier, start/busy/done.
// `define EARLY_ZERO_EN to finish a zero-operand multiply in one cycle.
module shift_add_multiplier
  import mul_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [31:0]  a,
  input  logic [31:0]  b,
  output logic         busy,
  output logic         done,
  output logic [63:0]  product
);
  if (WIDTH != 32) begin : g_width_chk
    $error("shift_add_multiplier: WIDTH must be 32");
  end
  if (CNT_W != 5) begin : g_cnt_chk
    $error("shift_add_multiplier: CNT_W must be 5");
  end

  state_e      state_q, state_d;
  logic [31:0] mcand_q, mcand_d;
  logic [63:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [63:0] prod_q, prod_d;

  logic [31:0] add_s;
  logic        add_c;

  Adder32Bit u_add (
    .a    (acc_q[63:32]),
    .b    (mcand_q),
    .cin  (1'b0),
    .sum  (add_s),
    .cout (add_c)
  );

  logic zero_op;
`ifdef EARLY_ZERO_EN
  assign zero_op = (a == 32'd0) || (b == 32'd0);
`else
  assign zero_op = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    prod_d  = prod_q;
    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          mcand_d = a;
          acc_d   = {32'd0, b};
          cnt_d   = '0;
          busy_d  = 1'b1;
          if (zero_op) begin
            prod_d  = '0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        // carry-out of the add becomes the new MSB
        if (acc_q[0]) acc_d = {add_c, add_s, acc_q[31:1]};
        else          acc_d = {1'b0, acc_q[63:1]};
        if (cnt_q == LAST_ITER) begin
          prod_d  = acc_d;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mcand_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      prod_q  <= prod_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = prod_q;
endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed table-driven bench for shift_add_multiplier.
// Define EARLY_ZERO_EN for both bench and RTL to test the early-zero build.
module tb_shift_add_multiplier;
  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [63:0] product;

  shift_add_multiplier dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass;
  int n_total;
  int n_done;

  always @(negedge clk) if (done) n_done++;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

`ifdef EARLY_ZERO_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 33;
`endif

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
  } vec_t;

  vec_t vecs[8];

  // pulse start for one cycle, then wait for done; lat counts negedges
  task automatic run_mul(input logic [31:0] ia, input logic [31:0] ib,
                         output int lat, output logic busy1);
    @(negedge clk);
    start = 1'b1;
    a = ia;
    b = ib;
    @(negedge clk);
    start = 1'b0;
    a = 32'hDEAD_BEEF;
    b = 32'hCAFE_F00D;
    lat = 1;
    busy1 = busy;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat;
    int gap;
    int bad;
    int d0;
    logic b1;
    n_pass = 0;
    n_total = 0;
    n_done = 0;
    start = 1'b0;
    a = '0;
    b = '0;
    rst_n = 1'b0;

    vecs[0] = '{32'd3, 32'd5, 64'd15};
    vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
    vecs[2] = '{32'd0, 32'h1234, 64'd0};
    vecs[3] = '{32'h1234, 32'd0, 64'd0};
    vecs[4] = '{32'h0001_0000, 32'h0001_0000, 64'h1_0000_0000};
    vecs[5] = '{32'h8000_0000, 32'd2, 64'h1_0000_0000};
    vecs[6] = '{32'd1, 32'hFFFF_FFFF, 64'h0000_0000_FFFF_FFFF};
    vecs[7] = '{32'hFFFF_FFFF, 32'd2, 64'h1_FFFF_FFFE};

    repeat (3) @(negedge clk);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_product", product, 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      int exp_lat;
      exp_lat = (vecs[i].a == 0 || vecs[i].b == 0) ? ZLAT : 33;
      run_mul(vecs[i].a, vecs[i].b, lat, b1);
      check($sformatf("v%0d_busy_next", i), {63'd0, b1}, 64'd1);
      check($sformatf("v%0d_latency", i), 64'(lat), 64'(exp_lat));
      check($sformatf("v%0d_product", i), product, vecs[i].p);
      @(negedge clk);
      check($sformatf("v%0d_done_pulse", i), {63'd0, done}, 64'd0);
      check($sformatf("v%0d_busy_after", i), {63'd0, busy}, 64'd0);
      check($sformatf("v%0d_product_hold", i), product, vecs[i].p);
    end

    // ignored start during RUN
    d0 = n_done;
    @(negedge clk);
    start = 1'b1; a = 32'd7; b = 32'd6;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1; a = 32'd1; b = 32'd1;
    @(negedge clk);
    start = 1'b0;
    repeat (60) @(negedge clk);
    check("ign_product", product, 64'd42);
    check("ign_done_count", 64'(n_done - d0), 64'd1);

    // back-to-back with start held high
    @(negedge clk);
    start = 1'b1; a = 32'd2; b = 32'd9;
    @(negedge clk);
    a = 32'd4; b = 32'd4;
    lat = 1;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("b2b_first_latency", 64'(lat), 64'd33);
    check("b2b_first_product", product, 64'd18);
    gap = 0;
    bad = 0;
    do begin
      @(negedge clk);
      gap++;
      if (busy && gap > 1) start = 1'b0;
      if (!done && product !== 64'd18) bad++;
    end while (!done && gap < 100);
    start = 1'b0;
    check("b2b_gap", 64'(gap), 64'd34);
    check("b2b_hold_errs", 64'(bad), 64'd0);
    check("b2b_second_product", product, 64'd16);
    repeat (3) @(negedge clk);

    // reset mid-RUN at cnt=10
    d0 = n_done;
    @(negedge clk);
    start = 1'b1; a = 32'd100; b = 32'd100;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_busy", {63'd0, busy}, 64'd0);
    check("rst_mid_done", {63'd0, done}, 64'd0);
    check("rst_mid_product", product, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("rst_no_done", 64'(n_done - d0), 64'd0);
    check("rst_product_zero", product, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
